// File: rtl/vga_pkg.sv
// =============================================================================
// Module   : vga_pkg
// Brief    : Shared key codes, PS/2 Set-2 scan codes and keyboard FSM states.
// Revision : 1.0
// =============================================================================
`default_nettype none

package vga_pkg;

   // Key codes consumed by the game and menu FSMs
   localparam logic [3:0] key_relesed = 4'b0000;
   localparam logic [3:0] key_A       = 4'b0001;
   localparam logic [3:0] key_S       = 4'b0010;
   localparam logic [3:0] key_W       = 4'b0011;
   localparam logic [3:0] key_D       = 4'b0100;
   localparam logic [3:0] key_1       = 4'b0101;
   localparam logic [3:0] key_2       = 4'b0110;
   localparam logic [3:0] key_3       = 4'b0111;
   localparam logic [3:0] key_4       = 4'b1000;
   localparam logic [3:0] key_esc     = 4'b1001;

   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } kbd_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_scan_to_key.sv
// =============================================================================
// Module   : ps2_scan_to_key
// Brief    : Combinational Set-2 scan-code to key-code lookup.
// Revision : 1.0
// =============================================================================
`default_nettype none

module ps2_scan_to_key
   import vga_pkg::*;
(
   input  logic [7:0] scan_code,
   output logic       key_valid,
   output logic [3:0] key
);

   always_comb begin
      key_valid = 1'b1;
      key       = key_relesed;
      case (scan_code)
         SC_A:    key = key_A;
         SC_S:    key = key_S;
         SC_W:    key = key_W;
         SC_D:    key = key_D;
         SC_1:    key = key_1;
         SC_2:    key = key_2;
         SC_3:    key = key_3;
         SC_4:    key = key_4;
         SC_ESC:  key = key_esc;
         default: key_valid = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// =============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 Set-2 byte stream to held-key code with break/extended/timeout handling.
// Revision : 1.0
// =============================================================================
`default_nettype none

module ps2_key_decoder
   import vga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 130_000,
   parameter bit REPEAT_EN      = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [3:0] key_code,
   output logic       key_event,
   output logic       prefix_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   kbd_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_key_valid;
   logic [3:0]       w_key;

   ps2_scan_to_key u_scan_to_key (
      .scan_code (scan_code),
      .key_valid (w_key_valid),
      .key       (w_key)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         key_code   <= key_relesed;
         key_event  <= 1'b0;
         prefix_err <= 1'b0;
      end else begin
         key_event  <= 1'b0;
         prefix_err <= 1'b0;
         // An arriving byte always takes priority over a terminal count.
         if (scan_valid) begin
            r_cnt <= '0;
            case (r_state)
               IDLE: begin
                  if (scan_code == SC_BREAK) begin
                     r_state <= BRK;
                  end else if (scan_code == SC_EXT) begin
                     r_state <= EXT;
                  end else if (w_key_valid) begin
                     if (w_key != key_code) begin
                        key_code  <= w_key;
                        key_event <= 1'b1;
                     end else if (REPEAT_EN) begin
                        key_event <= 1'b1;
                     end
                  end
               end
               BRK: begin
                  // Releasing a key other than the held one leaves key_code alone.
                  if (w_key_valid && (w_key == key_code)) begin
                     key_code  <= key_relesed;
                     key_event <= 1'b1;
                  end
                  r_state <= IDLE;
               end
               EXT: begin
                  r_state <= (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
               end
               EXT_BRK: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end else if (r_state != IDLE) begin
            if (r_cnt == C_CNT_LAST) begin
               r_state    <= IDLE;
               r_cnt      <= '0;
               prefix_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// =============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Randomized self-checking bench for ps2_key_decoder, both REPEAT_EN settings.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_ps2_key_decoder;

   localparam int T = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic [3:0] kc0, kc1;
   logic       ev0, ev1, pe0, pe1;

   always #5 clk = ~clk;

   ps2_key_decoder #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
      .key_code(kc0), .key_event(ev0), .prefix_err(pe0)
   );

   ps2_key_decoder #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
      .key_code(kc1), .key_event(ev1), .prefix_err(pe1)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: the pending prefix bytes are kept as a list, and a
   // sequence is interpreted once it is complete.
   logic [7:0] sc_table [9] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};
   int         m_code = 0;
   bit         m_ev0 = 0, m_ev1 = 0, m_err = 0;
   logic [7:0] seq [$];
   int         age = 0;

   function automatic int map_key(input logic [7:0] b);
      for (int i = 0; i < 9; i++) if (sc_table[i] == b) return i + 1;
      return -1;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int k;
      k = map_key(b);
      if (seq.size() == 0) begin
         if (b == 8'hF0 || b == 8'hE0) seq.push_back(b);
         else if (k > 0) begin
            if (k != m_code) begin
               m_code = k; m_ev0 = 1; m_ev1 = 1;
            end else m_ev1 = 1;
         end
      end else if (seq[0] == 8'hF0) begin
         if (k > 0 && k == m_code) begin
            m_code = 0; m_ev0 = 1; m_ev1 = 1;
         end
         seq.delete();
      end else begin
         if (seq.size() == 1 && b == 8'hF0) seq.push_back(b);
         else seq.delete();
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_code = 0; m_ev0 = 0; m_ev1 = 0; m_err = 0; age = 0;
         seq.delete();
      end else begin
         m_ev0 = 0; m_ev1 = 0; m_err = 0;
         if (scan_valid) begin
            model_byte(scan_code);
            age = 0;
         end else if (seq.size() > 0) begin
            age++;
            if (age == T) begin
               seq.delete();
               m_err = 1;
            end
         end
      end
   end

   bit chk_en = 0;
   bit prev_ev0 = 0, prev_ev1 = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("key_code0", kc0, m_code);
         chk("key_code1", kc1, m_code);
         chk("key_event0", ev0, m_ev0);
         chk("key_event1", ev1, m_ev1);
         chk("prefix_err0", pe0, m_err);
         chk("prefix_err1", pe1, m_err);
         chk("ev_back2back0", prev_ev0 & ev0, 0);
         chk("ev_back2back1", prev_ev1 & ev1, 0);
         prev_ev0 = ev0;
         prev_ev1 = ev1;
      end
   end

   // Caller is on a negedge; strobe spacing is sp cycles.
   task automatic send(input logic [7:0] b, input int sp);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      repeat (sp - 1) @(negedge clk);
   endtask

   initial begin
      int r, sp;
      logic [7:0] b;
      logic [7:0] junk [4] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE};
      chk_en = 1;
      repeat (3) @(negedge clk);
      chk("reset_code", kc0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h1C, 4); chk("t1_make", kc0, 4'b0001);
      send(8'hF0, 4); send(8'h1C, 4); chk("t1_break", kc0, 4'b0000);

      send(8'h1D, 4); send(8'h23, 4);
      send(8'hF0, 4); send(8'h1D, 4); chk("t2_stale_break", kc0, 4'b0100);
      send(8'hF0, 4); send(8'h23, 4); chk("t2_break", kc0, 4'b0000);

      repeat (3) send(8'h1B, 4);
      chk("t3_repeat", kc1, 4'b0010);

      send(8'hE0, 4); send(8'h75, 4);
      send(8'hE0, 4); send(8'hF0, 4); send(8'h75, 4);
      chk("t4_ext", kc0, 4'b0010);
      send(8'h76, 4); chk("t4_esc", kc0, 4'b1001);

      send(8'hF0, T + 1); send(8'h1C, 4); chk("t5_timeout_make", kc0, 4'b0001);
      send(8'hF0, T); send(8'h1C, 4); chk("t5_terminal_break", kc0, 4'b0000);

      send(8'h16, 4);
      scan_code = 8'hF0; scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("t6_async0", kc0, 0);
      chk("t6_async1", kc1, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send(8'h16, 4); chk("t6_make", kc0, 4'b0101);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      b = sc_table[$urandom_range(0, 8)];
         else if (r == 5) b = 8'hF0;
         else if (r == 6) b = 8'hE0;
         else if (r == 7) b = junk[$urandom_range(0, 3)];
         else             b = 8'($urandom_range(0, 255));
         sp = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(2, 5);
         send(b, sp);
      end

      repeat (T + 3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
